// File: rtl/bp_be_pkg.sv
// bp_be_pkg
//   Shared types and constants for the backend stride prefetch generator.
//   - bp_params_e / bp_vaddr_width(): processor configuration and the
//     virtual address width it implies.
//   - bp_be_pf_state_e: generator FSM states.
//   - bp_be_pf_stream_s: the single tracked stream (pc, step, next line
//     address, base page number, prefetches left to issue).
//   - bp_block_offset_width_gp: log2 of the default D$ line size.
package bp_be_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg
  } bp_params_e;

  localparam int bp_vaddr_width_gp        = 39;
  localparam int bp_pf_remaining_width_gp = 4;
  localparam int bp_block_width_bytes_gp  = 64;
  localparam int bp_block_offset_width_gp = $clog2(bp_block_width_bytes_gp);

  function automatic int bp_vaddr_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return bp_vaddr_width_gp;
      default:          return bp_vaddr_width_gp;
    endcase
  endfunction

  typedef enum logic [1:0] {
    e_idle,
    e_train,
    e_issue
  } bp_be_pf_state_e;

  // base_page holds the page number right-justified (address >> page offset)
  typedef struct packed {
    logic [bp_vaddr_width_gp-1:0]        pc;
    logic [bp_vaddr_width_gp-1:0]        step;
    logic [bp_vaddr_width_gp-1:0]        next_vaddr;
    logic [bp_vaddr_width_gp-1:0]        base_page;
    logic [bp_pf_remaining_width_gp-1:0] remaining;
  } bp_be_pf_stream_s;

endpackage

// File: rtl/bp_be_pf_addr_step.sv
// bp_be_pf_addr_step
//   Purely combinational address helper for the stride prefetcher.
//   Ports:
//     stride_i        signed byte stride from the stride detector
//     eff_addr_i      effective address of the confirming load
//     cur_vaddr_i     line address currently held by the stream
//     cur_step_i      step currently held by the stream
//     base_page_i     page number the stream is confined to
//     step_o          stride scaled up to at least one line, sign kept
//     stride_zero_o   stride_i is zero
//     first_vaddr_o   align(eff_addr_i + step_o)
//     advance_vaddr_o align(cur_vaddr_i + cur_step_i)
//     eff_page_o      page number of eff_addr_i
//     page_cross_o    cur_vaddr_i lies outside base_page_i
module bp_be_pf_addr_step #(
  parameter int vaddr_width_p       = 39,
  parameter int stride_width_p      = 8,
  parameter int block_width_bytes_p = 64,
  parameter int page_offset_width_p = 12
) (
  input  logic [stride_width_p-1:0] stride_i,
  input  logic [vaddr_width_p-1:0]  eff_addr_i,
  input  logic [vaddr_width_p-1:0]  cur_vaddr_i,
  input  logic [vaddr_width_p-1:0]  cur_step_i,
  input  logic [vaddr_width_p-1:0]  base_page_i,
  output logic [vaddr_width_p-1:0]  step_o,
  output logic                      stride_zero_o,
  output logic [vaddr_width_p-1:0]  first_vaddr_o,
  output logic [vaddr_width_p-1:0]  advance_vaddr_o,
  output logic [vaddr_width_p-1:0]  eff_page_o,
  output logic                      page_cross_o
);

  localparam int block_offset_width_lp = $clog2(block_width_bytes_p);
  localparam logic [vaddr_width_p-1:0] block_bytes_lp = vaddr_width_p'(block_width_bytes_p);
  localparam logic [vaddr_width_p-1:0] align_mask_lp =
    {{(vaddr_width_p-block_offset_width_lp){1'b1}}, {block_offset_width_lp{1'b0}}};

  logic                     stride_neg;
  logic [vaddr_width_p-1:0] stride_sext;
  logic [vaddr_width_p-1:0] stride_mag;

  // Magnitude is taken after widening so the most negative stride does not overflow
  assign stride_neg    = stride_i[stride_width_p-1];
  assign stride_sext   = {{(vaddr_width_p-stride_width_p){stride_neg}}, stride_i};
  assign stride_mag    = stride_neg ? (-stride_sext) : stride_sext;
  assign stride_zero_o = (stride_i == '0);

  // Strides shorter than a line would re-fetch the same line, so they are
  // rounded up to one line in the stride's direction
  always_comb begin
    step_o = '0;
    if (stride_zero_o) begin
      step_o = '0;
    end else if (stride_mag >= block_bytes_lp) begin
      step_o = stride_sext;
    end else if (stride_neg) begin
      step_o = -block_bytes_lp;
    end else begin
      step_o = block_bytes_lp;
    end
  end

  assign first_vaddr_o   = (eff_addr_i + step_o) & align_mask_lp;
  assign advance_vaddr_o = (cur_vaddr_i + cur_step_i) & align_mask_lp;
  assign eff_page_o      = eff_addr_i >> page_offset_width_p;
  assign page_cross_o    = ((cur_vaddr_i >> page_offset_width_p) != base_page_i);

endmodule

// File: rtl/bp_be_stride_pf_gen.sv
// bp_be_stride_pf_gen
//   Stride prefetch request generator fed by the backend load-stride
//   detector. Tracks one stream; after confirmation it issues up to
//   pf_degree_p line-aligned prefetch vaddrs over a valid/ready port.
//   Ports:
//     clk_i, reset_i        clock, synchronous active-high reset
//     stride_v_i            stride/pc/eff_addr/discovery inputs valid
//     stride_i              detected stride, signed bytes
//     pc_i, eff_addr_i      PC and effective address of the striding load
//     start_discovery_i     new stream candidate
//     confirm_discovery_i   stream confirmed
//     pf_v_o, pf_vaddr_o    prefetch request, line-aligned vaddr
//     pf_ready_i            D$ accepts the request
//     busy_o                generator not idle
//   Build option: define BP_BE_PF_PAGE_CROSS_EN to let a stream run across
//   page boundaries; by default a stream stops at the confirming page.
module bp_be_stride_pf_gen
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p   = e_bp_default_cfg,
  localparam int vaddr_width_p        = bp_vaddr_width(bp_params_p),
  parameter int stride_width_p        = 8,
  parameter int pf_degree_p           = 4,
  parameter int block_width_bytes_p   = 64,
  parameter int page_offset_width_p   = 12
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      stride_v_i,
  input  logic [stride_width_p-1:0] stride_i,
  input  logic [vaddr_width_p-1:0]  pc_i,
  input  logic [vaddr_width_p-1:0]  eff_addr_i,
  input  logic                      start_discovery_i,
  input  logic                      confirm_discovery_i,
  output logic                      pf_v_o,
  output logic [vaddr_width_p-1:0]  pf_vaddr_o,
  input  logic                      pf_ready_i,
  output logic                      busy_o
);

  bp_be_pf_state_e  state_r, state_n;
  bp_be_pf_stream_s stream_r, stream_n;

  logic [vaddr_width_p-1:0] step;
  logic                     stride_zero;
  logic [vaddr_width_p-1:0] first_vaddr;
  logic [vaddr_width_p-1:0] advance_vaddr;
  logic [vaddr_width_p-1:0] eff_page;
  logic                     page_cross;
  logic                     page_stop;
  logic                     start;
  logic                     confirm;
  logic                     xfer;
  logic                     unused;

  bp_be_pf_addr_step #(
    .vaddr_width_p       (vaddr_width_p),
    .stride_width_p      (stride_width_p),
    .block_width_bytes_p (block_width_bytes_p),
    .page_offset_width_p (page_offset_width_p)
  ) addr_step (
    .stride_i        (stride_i),
    .eff_addr_i      (eff_addr_i),
    .cur_vaddr_i     (stream_r.next_vaddr),
    .cur_step_i      (stream_r.step),
    .base_page_i     (stream_r.base_page),
    .step_o          (step),
    .stride_zero_o   (stride_zero),
    .first_vaddr_o   (first_vaddr),
    .advance_vaddr_o (advance_vaddr),
    .eff_page_o      (eff_page),
    .page_cross_o    (page_cross)
  );

`ifdef BP_BE_PF_PAGE_CROSS_EN
  assign page_stop = 1'b0;
  assign unused    = ^{stream_r.pc, page_cross};
`else
  // The held address already left the base page: never present it
  assign page_stop = (state_r == e_issue) & page_cross;
  assign unused    = ^stream_r.pc;
`endif

  assign start   = stride_v_i & start_discovery_i;
  assign confirm = stride_v_i & confirm_discovery_i;

  // Request outputs come straight from registers so the address is stable under backpressure
  always_comb begin
    pf_v_o     = 1'b0;
    pf_vaddr_o = stream_r.next_vaddr;
    busy_o     = (state_r != e_idle);
    pf_v_o     = (state_r == e_issue) & ~page_stop;
  end

  assign xfer = pf_v_o & pf_ready_i;

  // Next-state: start beats confirm, and a confirm while issuing reloads
  // the stream in place of that cycle's transfer update
  always_comb begin
    state_n  = state_r;
    stream_n = stream_r;
    case (state_r)
      e_idle: begin
        if (start) begin
          stream_n.pc = pc_i;
          state_n     = e_train;
        end
      end
      e_train, e_issue: begin
        if (start) begin
          stream_n.pc = pc_i;
          state_n     = e_train;
        end else if (confirm) begin
          if (stride_zero) begin
            state_n = e_idle;
          end else begin
            stream_n.step       = step;
            stream_n.next_vaddr = first_vaddr;
            stream_n.base_page  = eff_page;
            stream_n.remaining  = bp_pf_remaining_width_gp'(pf_degree_p);
            state_n             = e_issue;
          end
        end else if (state_r == e_issue) begin
          if (page_stop) begin
            state_n = e_idle;
          end else if (xfer) begin
            if (stream_r.remaining == bp_pf_remaining_width_gp'(1)) begin
              state_n = e_idle;
            end else begin
              stream_n.next_vaddr = advance_vaddr;
              stream_n.remaining  = stream_r.remaining - bp_pf_remaining_width_gp'(1);
            end
          end
        end
      end
      default: state_n = e_idle;
    endcase
  end

  // State and stream registers with synchronous clear
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= e_idle;
      stream_r <= '0;
    end else begin
      state_r  <= state_n;
      stream_r <= stream_n;
    end
  end

endmodule

// File: tb/tb_bp_be_stride_pf_gen.sv
// tb_bp_be_stride_pf_gen
//   Directed scenarios with fixed expected addresses, followed by a random
//   phase, all compared every cycle against a stream model that expands a
//   confirmation into the list of line addresses it should produce.
//   Honours BP_BE_PF_PAGE_CROSS_EN the same way the design does.
module tb_bp_be_stride_pf_gen;
  import bp_be_pkg::*;

  localparam int vw     = bp_vaddr_width_gp;
  localparam int degree = 4;
  localparam int blk    = 64;
  localparam int po     = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          stride_v;
  logic [7:0]    stride;
  logic [vw-1:0] pc;
  logic [vw-1:0] eff_addr;
  logic          start_discovery;
  logic          confirm_discovery;
  logic          pf_v;
  logic [vw-1:0] pf_vaddr;
  logic          pf_ready;
  logic          busy;

  int checks = 0;
  int errors = 0;

  bp_be_stride_pf_gen #(
    .bp_params_p         (e_bp_default_cfg),
    .stride_width_p      (8),
    .pf_degree_p         (degree),
    .block_width_bytes_p (blk),
    .page_offset_width_p (po)
  ) dut (
    .clk_i               (clk),
    .reset_i             (reset),
    .stride_v_i          (stride_v),
    .stride_i            (stride),
    .pc_i                (pc),
    .eff_addr_i          (eff_addr),
    .start_discovery_i   (start_discovery),
    .confirm_discovery_i (confirm_discovery),
    .pf_v_o              (pf_v),
    .pf_vaddr_o          (pf_vaddr),
    .pf_ready_i          (pf_ready),
    .busy_o              (busy)
  );

  always #5 clk = ~clk;

  // Reference model: mode plus the queue of addresses still to be offered
  typedef enum int {m_idle, m_train, m_issue} m_mode_e;
  m_mode_e       m_mode = m_idle;
  logic [vw-1:0] m_q[$];
  bit            m_stop_tail = 1'b0;

  function automatic logic [vw-1:0] m_align(logic [vw-1:0] a);
    logic [vw-1:0] mask;
    mask = ~vw'(blk - 1);
    return a & mask;
  endfunction

  function automatic logic [vw-1:0] m_step(logic [7:0] s);
    int sv;
    int mag;
    sv  = int'($signed(s));
    mag = (sv < 0) ? -sv : sv;
    if (sv == 0) return '0;
    if (mag >= blk) return vw'(sv);
    if (sv < 0) return vw'(-blk);
    return vw'(blk);
  endfunction

  task automatic m_load(logic [7:0] s, logic [vw-1:0] e);
    logic [vw-1:0] st;
    logic [vw-1:0] a;
    logic [vw-1:0] page;
    st   = m_step(s);
    a    = e;
    page = e >> po;
    m_q.delete();
    m_stop_tail = 1'b0;
    for (int k = 0; k < degree; k++) begin
      a = m_align(a + st);
`ifndef BP_BE_PF_PAGE_CROSS_EN
      if ((a >> po) != page) begin
        m_stop_tail = 1'b1;
        break;
      end
`endif
      m_q.push_back(a);
    end
  endtask

  task automatic m_clock(bit r, bit v, bit st, bit cf, bit rdy, logic [7:0] s, logic [vw-1:0] e);
    if (r) begin
      m_mode = m_idle;
      m_q.delete();
      m_stop_tail = 1'b0;
      return;
    end
    case (m_mode)
      m_idle: if (v && st) m_mode = m_train;
      m_train: begin
        if (v && st) m_mode = m_train;
        else if (v && cf) begin
          if (s == 8'h00) m_mode = m_idle;
          else begin m_load(s, e); m_mode = m_issue; end
        end
      end
      default: begin
        if (v && st) m_mode = m_train;
        else if (v && cf) begin
          if (s == 8'h00) m_mode = m_idle;
          else m_load(s, e);
        end else if (m_q.size() == 0) m_mode = m_idle;
        else if (rdy) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0 && !m_stop_tail) m_mode = m_idle;
        end
      end
    endcase
  endtask

  task automatic check_output(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge
  task automatic apply_stimulus(bit r, bit v, bit st, bit cf, bit rdy,
                                logic [7:0] s, logic [vw-1:0] e, string tag);
    bit exp_v;
    reset             = r;
    stride_v          = v;
    start_discovery   = st;
    confirm_discovery = cf;
    pf_ready          = rdy;
    stride            = s;
    eff_addr          = e;
    pc                = {7'($urandom), 32'($urandom)};
    m_clock(r, v, st, cf, rdy, s, e);
    @(negedge clk);
    exp_v = (m_mode == m_issue) && (m_q.size() != 0);
    check_output({tag, ".pf_v"}, 64'(pf_v), 64'(exp_v));
    check_output({tag, ".busy"}, 64'(busy), 64'(m_mode != m_idle));
    if (exp_v) check_output({tag, ".pf_vaddr"}, 64'(pf_vaddr), 64'(m_q[0]));
  endtask

  task automatic idle_tick(bit rdy, string tag);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, rdy, 8'h00, '0, tag);
  endtask

  task automatic start_tick(logic [vw-1:0] e, string tag);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h08, e, tag);
  endtask

  task automatic confirm_tick(logic [7:0] s, logic [vw-1:0] e, string tag);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, s, e, tag);
  endtask

  initial begin
    logic [7:0]    rs;
    logic [vw-1:0] re;

    @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, '0, "reset0");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, '0, "reset1");
    check_output("reset.pf_vaddr", 64'(pf_vaddr), 64'h0);
    check_output("reset.busy", 64'(busy), 64'h0);

    // Basic stream, stride 8 rounds up to one line
    start_tick(39'h1000, "basic.start");
    check_output("basic.train_busy", 64'(busy), 64'h1);
    confirm_tick(8'h08, 39'h1000, "basic.confirm");
    check_output("basic.a0", 64'(pf_vaddr), 64'h1040);
    idle_tick(1'b1, "basic.t1");
    check_output("basic.a1", 64'(pf_vaddr), 64'h1080);
    idle_tick(1'b1, "basic.t2");
    check_output("basic.a2", 64'(pf_vaddr), 64'h10C0);
    idle_tick(1'b1, "basic.t3");
    check_output("basic.a3", 64'(pf_vaddr), 64'h1100);
    idle_tick(1'b1, "basic.t4");
    check_output("basic.done_busy", 64'(busy), 64'h0);

    // Backpressure with stride -128 inside one page
    start_tick(39'h2800, "bp.start");
    confirm_tick(8'h80, 39'h2800, "bp.confirm");
    for (int i = 0; i < 3; i++) begin
      idle_tick(1'b0, "bp.hold");
      check_output("bp.held", 64'(pf_vaddr), 64'h2780);
      check_output("bp.held_v", 64'(pf_v), 64'h1);
    end
    idle_tick(1'b1, "bp.t1");
    check_output("bp.a1", 64'(pf_vaddr), 64'h2700);
    idle_tick(1'b1, "bp.t2");
    check_output("bp.a2", 64'(pf_vaddr), 64'h2680);
    idle_tick(1'b1, "bp.t3");
    check_output("bp.a3", 64'(pf_vaddr), 64'h2600);
    idle_tick(1'b1, "bp.t4");
    check_output("bp.done_busy", 64'(busy), 64'h0);

    // Stride -128 from a page start: first line is already on the previous page
    start_tick(39'h2000, "neg_page.start");
    confirm_tick(8'h80, 39'h2000, "neg_page.confirm");
`ifdef BP_BE_PF_PAGE_CROSS_EN
    check_output("neg_page.a0", 64'(pf_vaddr), 64'h1F80);
`else
    check_output("neg_page.v0", 64'(pf_v), 64'h0);
`endif
    for (int i = 0; i < 5; i++) idle_tick(1'b1, "neg_page.drain");
    check_output("neg_page.done_busy", 64'(busy), 64'h0);

    // Page stop at the top of a page
    start_tick(39'h1F80, "page.start");
    confirm_tick(8'h40, 39'h1F80, "page.confirm");
    check_output("page.a0", 64'(pf_vaddr), 64'h1FC0);
    idle_tick(1'b1, "page.t1");
`ifdef BP_BE_PF_PAGE_CROSS_EN
    check_output("page.a1", 64'(pf_vaddr), 64'h2000);
    idle_tick(1'b1, "page.t2");
    check_output("page.a2", 64'(pf_vaddr), 64'h2040);
    idle_tick(1'b1, "page.t3");
    check_output("page.a3", 64'(pf_vaddr), 64'h2080);
`else
    check_output("page.stop_v", 64'(pf_v), 64'h0);
`endif
    idle_tick(1'b1, "page.end");
    check_output("page.done_busy", 64'(busy), 64'h0);

    // Abort on a new start during the second request, zero-stride confirm, stray confirm
    start_tick(39'h1000, "abort.start");
    confirm_tick(8'h40, 39'h1000, "abort.confirm");
    idle_tick(1'b1, "abort.t1");
    check_output("abort.a1", 64'(pf_vaddr), 64'h1080);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h40, 39'h1000, "abort.restart");
    check_output("abort.v", 64'(pf_v), 64'h0);
    check_output("abort.train_busy", 64'(busy), 64'h1);
    confirm_tick(8'h00, 39'h1000, "zero.confirm");
    check_output("zero.busy", 64'(busy), 64'h0);
    confirm_tick(8'h08, 39'h4000, "stray.confirm");
    check_output("stray.busy", 64'(busy), 64'h0);
    check_output("stray.v", 64'(pf_v), 64'h0);

    // Retarget mid-stream, overriding that cycle's transfer
    start_tick(39'h1000, "retarget.start");
    confirm_tick(8'h40, 39'h1000, "retarget.confirm0");
    confirm_tick(8'h40, 39'h3000, "retarget.confirm1");
    check_output("retarget.a0", 64'(pf_vaddr), 64'h3040);
    idle_tick(1'b1, "retarget.t1");
    check_output("retarget.a1", 64'(pf_vaddr), 64'h3080);
    idle_tick(1'b1, "retarget.t2");
    check_output("retarget.a2", 64'(pf_vaddr), 64'h30C0);
    idle_tick(1'b1, "retarget.t3");
    check_output("retarget.a3", 64'(pf_vaddr), 64'h3100);
    idle_tick(1'b1, "retarget.t4");
    check_output("retarget.done_busy", 64'(busy), 64'h0);

    // Reset while a request is pending
    start_tick(39'h1000, "rst.start");
    confirm_tick(8'h40, 39'h1000, "rst.confirm");
    check_output("rst.pending_v", 64'(pf_v), 64'h1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, '0, "rst.apply");
    check_output("rst.v", 64'(pf_v), 64'h0);
    check_output("rst.pf_vaddr", 64'(pf_vaddr), 64'h0);
    check_output("rst.busy", 64'(busy), 64'h0);

    // Random traffic against the model (nonzero strides only)
    for (int i = 0; i < 1500; i++) begin
      rs = 8'($urandom);
      if (rs == 8'h00) rs = 8'h40;
      re = {7'($urandom), 32'($urandom)};
      if ($urandom_range(1, 0) == 1) re[11:0] = 12'hF00 | 12'($urandom_range(255, 0));
      apply_stimulus(($urandom_range(63, 0) == 0),
                     ($urandom_range(3, 0) != 0),
                     ($urandom_range(11, 0) == 0),
                     ($urandom_range(5, 0) == 0),
                     ($urandom_range(2, 0) != 0),
                     rs, re, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
